// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 matrix keypad scanner with 2-flop column synchronizer,
// press/release debounce and a one-clock key_valid pulse per accepted key.
// Optional auto-repeat while a key is held is enabled by defining the
// macro KEYPAD_REPEAT_EN; without it each press yields exactly one pulse.
module keypad_scan #(
  parameter int SCAN_DIV     = 25000,
  parameter int DEBOUNCE_CNT = 4,
  parameter int REPEAT_DLY   = 250,
  parameter int REPEAT_RATE  = 50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] col,
  output logic [3:0] row,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_down
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int DEB_W = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0] DEB_DONE = DEB_W'(DEBOUNCE_CNT);

  // Reject parameter values the scanner cannot honour at elaboration time.
  if (SCAN_DIV < 2 || DEBOUNCE_CNT < 1 || REPEAT_DLY < 1 || REPEAT_RATE < 1) begin : g_bad_params
    $error("keypad_scan: illegal parameter value");
  end

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HOLD} state_t;

  state_t           r_state, w_state_next;
  logic [3:0]       r_col_meta, r_col_s;
  logic [DIV_W-1:0] r_div;
  logic [1:0]       r_row_idx, w_row_idx_next;
  logic [3:0]       r_row;
  logic [3:0]       r_pat, w_pat_next;
  logic [1:0]       r_col_idx, w_col_idx_next;
  logic [DEB_W-1:0] r_deb_cnt, w_deb_next, w_deb_inc;
  logic [DEB_W-1:0] r_rel_cnt, w_rel_next, w_rel_inc;
  logic [3:0]       r_key_code;
  logic             r_key_valid, r_key_down;
  logic             w_tick, w_one_low, w_accept, w_release, w_repeat;
  logic [1:0]       w_hit_idx, w_rot_idx;

`ifdef KEYPAD_REPEAT_EN
  localparam int REP_MAX = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
  localparam int REP_W   = $clog2(REP_MAX + 1);
  logic [REP_W-1:0] r_rep_cnt, w_rep_next, w_rep_inc;
  logic             r_rep_first, w_rep_first_next;
`endif

  assign w_tick    = (r_div == DIV_LAST);
  assign w_rot_idx = r_row_idx + 2'd1;
  assign w_deb_inc = r_deb_cnt + 1'b1;
  assign w_rel_inc = r_rel_cnt + 1'b1;
`ifdef KEYPAD_REPEAT_EN
  assign w_rep_inc = r_rep_cnt + 1'b1;
`endif

  // Decode the synchronized columns: valid only when exactly one column is low.
  always_comb begin
    w_one_low = 1'b1;
    w_hit_idx = 2'd0;
    case (r_col_s)
      4'b1110: w_hit_idx = 2'd0;
      4'b1101: w_hit_idx = 2'd1;
      4'b1011: w_hit_idx = 2'd2;
      4'b0111: w_hit_idx = 2'd3;
      default: w_one_low = 1'b0;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= SCAN;
    else     r_state <= w_state_next;
  end

  // Next-state and counter logic; everything advances only on scan ticks.
  always_comb begin
    w_state_next   = r_state;
    w_row_idx_next = r_row_idx;
    w_pat_next     = r_pat;
    w_col_idx_next = r_col_idx;
    w_deb_next     = r_deb_cnt;
    w_rel_next     = r_rel_cnt;
    w_accept       = 1'b0;
    w_release      = 1'b0;
    w_repeat       = 1'b0;
`ifdef KEYPAD_REPEAT_EN
    w_rep_next       = r_rep_cnt;
    w_rep_first_next = r_rep_first;
`endif
    if (w_tick) begin
      case (r_state)
        SCAN: begin
          if (w_one_low) begin
            w_pat_next     = r_col_s;
            w_col_idx_next = w_hit_idx;
            w_deb_next     = DEB_W'(1);
            w_rel_next     = '0;
            if (DEBOUNCE_CNT == 1) begin
              w_accept     = 1'b1;
              w_state_next = HOLD;
            end else begin
              w_state_next = DEBOUNCE;
            end
          end else begin
            w_row_idx_next = w_rot_idx;
          end
        end
        DEBOUNCE: begin
          if (r_col_s == r_pat) begin
            w_deb_next = w_deb_inc;
            if (w_deb_inc == DEB_DONE) begin
              w_accept     = 1'b1;
              w_rel_next   = '0;
              w_state_next = HOLD;
            end
          end else begin
            w_deb_next     = '0;
            w_row_idx_next = w_rot_idx;
            w_state_next   = SCAN;
          end
        end
        HOLD: begin
          if (r_col_s == 4'hF) begin
            if (w_rel_inc == DEB_DONE) begin
              w_release      = 1'b1;
              w_rel_next     = '0;
              w_deb_next     = '0;
              w_row_idx_next = w_rot_idx;
              w_state_next   = SCAN;
            end else begin
              w_rel_next = w_rel_inc;
            end
          end else begin
            w_rel_next = '0;
          end
`ifdef KEYPAD_REPEAT_EN
          if (r_col_s == r_pat) begin
            if (w_rep_inc == (r_rep_first ? REP_W'(REPEAT_DLY) : REP_W'(REPEAT_RATE))) begin
              w_repeat         = 1'b1;
              w_rep_next       = '0;
              w_rep_first_next = 1'b0;
            end else begin
              w_rep_next = w_rep_inc;
            end
          end else begin
            w_rep_next = '0;
          end
`endif
        end
        default: w_state_next = SCAN;
      endcase
    end
`ifdef KEYPAD_REPEAT_EN
    // A fresh acceptance restarts the repeat timer with the long initial delay.
    if (w_accept) begin
      w_rep_next       = '0;
      w_rep_first_next = 1'b1;
    end
`endif
  end

  // Synchronizer, divider, scan datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_col_meta  <= 4'hF;
      r_col_s     <= 4'hF;
      r_div       <= '0;
      r_row_idx   <= 2'd0;
      r_row       <= 4'b1110;
      r_pat       <= 4'hF;
      r_col_idx   <= 2'd0;
      r_deb_cnt   <= '0;
      r_rel_cnt   <= '0;
      r_key_code  <= 4'h0;
      r_key_valid <= 1'b0;
      r_key_down  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      r_rep_cnt   <= '0;
      r_rep_first <= 1'b1;
`endif
    end else begin
      r_col_meta  <= col;
      r_col_s     <= r_col_meta;
      r_div       <= w_tick ? '0 : r_div + 1'b1;
      r_row_idx   <= w_row_idx_next;
      r_row       <= ~(4'b0001 << w_row_idx_next);
      r_pat       <= w_pat_next;
      r_col_idx   <= w_col_idx_next;
      r_deb_cnt   <= w_deb_next;
      r_rel_cnt   <= w_rel_next;
      r_key_valid <= w_accept | w_repeat;
      if (w_accept) begin
        r_key_code <= {r_row_idx, w_col_idx_next};
        r_key_down <= 1'b1;
      end else if (w_release) begin
        r_key_down <= 1'b0;
      end
`ifdef KEYPAD_REPEAT_EN
      r_rep_cnt   <= w_rep_next;
      r_rep_first <= w_rep_first_next;
`endif
    end
  end

  assign row       = r_row;
  assign key_code  = r_key_code;
  assign key_valid = r_key_valid;
  assign key_down  = r_key_down;

endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan: directed bench for keypad_scan with SCAN_DIV=4,
// DEBOUNCE_CNT=3, REPEAT_DLY=5, REPEAT_RATE=2. A keypad model pulls one
// column pattern low whenever the chosen row is driven. cyc counts clock
// edges since reset release, so scan ticks land on edges where cyc%4==0.
// Define KEYPAD_REPEAT_EN for both bench and RTL to check auto-repeat.
module tb_keypad_scan;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] col;
  logic [3:0] row;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_down;

  keypad_scan #(
    .SCAN_DIV    (4),
    .DEBOUNCE_CNT(3),
    .REPEAT_DLY  (5),
    .REPEAT_RATE (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .col      (col),
    .row      (row),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_down (key_down)
  );

  always #5 clk = ~clk;

  // Keypad model: the pressed switch connects row p_row to the columns in p_mask.
  logic       press_en = 1'b0;
  logic [1:0] p_row    = 2'd0;
  logic [3:0] p_mask   = 4'hF;
  always_comb col = (press_en && row[p_row] == 1'b0) ? p_mask : 4'hF;

  int cyc = 0;
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // Pulse recorder: cycle and code of every key_valid pulse.
  int         pulse_cnt = 0;
  int         pulse_cyc [64];
  logic [3:0] pulse_code[64];
  always @(negedge clk) begin
    if (rst === 1'b0 && key_valid === 1'b1) begin
      if (pulse_cnt < 64) begin
        pulse_cyc[pulse_cnt]  = cyc;
        pulse_code[pulse_cnt] = key_code;
      end
      pulse_cnt = pulse_cnt + 1;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    n_cmp++; if (row !== 4'b1110) begin n_bad++; $display("FAIL reset_row got=%b exp=%b", row, 4'b1110); end
    n_cmp++; if (key_code !== 4'h0) begin n_bad++; $display("FAIL reset_code got=%h exp=%h", key_code, 4'h0); end
    n_cmp++; if (key_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got=%b exp=0", key_valid); end
    n_cmp++; if (key_down !== 1'b0) begin n_bad++; $display("FAIL reset_down got=%b exp=0", key_down); end
    $display("reset: row=%b code=%h valid=%b down=%b", row, key_code, key_valid, key_down);
  endtask

  task automatic test_idle_scan();
    int base;
    logic [3:0] exp_row;
    base = pulse_cnt;
    for (int n = 1; n <= 40; n++) begin
      step(1);
      if (n % 4 == 0) begin
        exp_row = ~(4'b0001 << ((n / 4) % 4));
        n_cmp++; if (row !== exp_row) begin n_bad++; $display("FAIL idle_row cyc=%0d got=%b exp=%b", cyc, row, exp_row); end
      end
    end
    n_cmp++; if (pulse_cnt - base !== 0) begin n_bad++; $display("FAIL idle_pulses got=%0d exp=0", pulse_cnt - base); end
    n_cmp++; if (key_down !== 1'b0) begin n_bad++; $display("FAIL idle_down got=%b exp=0", key_down); end
    $display("idle: 40 clk scanned, pulses=%0d", pulse_cnt - base);
  endtask

  // Starts at cyc 40 with row2 driven; key row2/col1 -> code 9.
  task automatic test_single_press();
    int base;
    base = pulse_cnt;
    p_row = 2'd2; p_mask = 4'b1101; press_en = 1'b1;
    step(12);
    n_cmp++; if (pulse_cnt - base !== 1) begin n_bad++; $display("FAIL press_pulses got=%0d exp=1", pulse_cnt - base); end
    n_cmp++; if (pulse_cyc[base] !== 52) begin n_bad++; $display("FAIL press_latency got=%0d exp=52", pulse_cyc[base]); end
    n_cmp++; if (key_code !== 4'h9) begin n_bad++; $display("FAIL press_code got=%h exp=9", key_code); end
    n_cmp++; if (key_down !== 1'b1) begin n_bad++; $display("FAIL press_down got=%b exp=1", key_down); end
    step(1);
    n_cmp++; if (key_valid !== 1'b0) begin n_bad++; $display("FAIL press_pulse_width got=%b exp=0", key_valid); end
    step(27);
    n_cmp++; if (pulse_cnt - base !== 1) begin n_bad++; $display("FAIL press_single got=%0d exp=1", pulse_cnt - base); end
    press_en = 1'b0;
    step(11);
    n_cmp++; if (key_down !== 1'b1) begin n_bad++; $display("FAIL release_early got=%b exp=1", key_down); end
    step(1);
    n_cmp++; if (key_down !== 1'b0) begin n_bad++; $display("FAIL release_down got=%b exp=0", key_down); end
    n_cmp++; if (row !== 4'b0111) begin n_bad++; $display("FAIL release_row got=%b exp=0111", row); end
    $display("single press: code=%h pulses=%0d released at cyc=%0d", key_code, pulse_cnt - base, cyc);
  endtask

  // Starts at cyc 92 with row3 driven; bounce on row0/col3 -> code 3.
  task automatic test_bounce();
    int base;
    base = pulse_cnt;
    step(4);
    n_cmp++; if (row !== 4'b1110) begin n_bad++; $display("FAIL bounce_row0 got=%b exp=1110", row); end
    p_row = 2'd0; p_mask = 4'b0111; press_en = 1'b1;
    step(8);
    press_en = 1'b0;
    step(4);
    n_cmp++; if (row !== 4'b1101) begin n_bad++; $display("FAIL bounce_reject_row got=%b exp=1101", row); end
    n_cmp++; if (pulse_cnt - base !== 0) begin n_bad++; $display("FAIL bounce_reject got=%0d exp=0", pulse_cnt - base); end
    press_en = 1'b1;
    step(24);
    n_cmp++; if (pulse_cnt - base !== 1) begin n_bad++; $display("FAIL bounce_accept got=%0d exp=1", pulse_cnt - base); end
    n_cmp++; if (pulse_cyc[base] !== 132) begin n_bad++; $display("FAIL bounce_latency got=%0d exp=132", pulse_cyc[base]); end
    n_cmp++; if (key_code !== 4'h3) begin n_bad++; $display("FAIL bounce_code got=%h exp=3", key_code); end
    step(8);
    press_en = 1'b0;
    step(12);
    n_cmp++; if (key_down !== 1'b0) begin n_bad++; $display("FAIL bounce_release got=%b exp=0", key_down); end
    n_cmp++; if (pulse_cnt - base !== 1) begin n_bad++; $display("FAIL bounce_total got=%0d exp=1", pulse_cnt - base); end
    $display("bounce: code=%h pulses=%0d", key_code, pulse_cnt - base);
  endtask

  // Starts at cyc 152 with row1 driven; two columns low on row1.
  task automatic test_multi_key();
    int base;
    logic [3:0] exp_row;
    base = pulse_cnt;
    p_row = 2'd1; p_mask = 4'b1100; press_en = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step(4);
      exp_row = ~(4'b0001 << ((1 + k) % 4));
      n_cmp++; if (row !== exp_row) begin n_bad++; $display("FAIL multi_row cyc=%0d got=%b exp=%b", cyc, row, exp_row); end
    end
    n_cmp++; if (pulse_cnt - base !== 0) begin n_bad++; $display("FAIL multi_pulses got=%0d exp=0", pulse_cnt - base); end
    n_cmp++; if (key_down !== 1'b0) begin n_bad++; $display("FAIL multi_down got=%b exp=0", key_down); end
    press_en = 1'b0;
    $display("multi-key: pulses=%0d", pulse_cnt - base);
  endtask

  // Starts at cyc 184 with row1 driven; reset lands after one debounce sample.
  task automatic test_reset_mid_debounce();
    int base;
    p_row = 2'd1; p_mask = 4'b1110; press_en = 1'b1;
    step(4);
    n_cmp++; if (row !== 4'b1101) begin n_bad++; $display("FAIL middeb_held got=%b exp=1101", row); end
    rst = 1'b1;
    step(1);
    n_cmp++; if (row !== 4'b1110) begin n_bad++; $display("FAIL middeb_row got=%b exp=1110", row); end
    n_cmp++; if (key_down !== 1'b0) begin n_bad++; $display("FAIL middeb_down got=%b exp=0", key_down); end
    n_cmp++; if (key_valid !== 1'b0) begin n_bad++; $display("FAIL middeb_valid got=%b exp=0", key_valid); end
    n_cmp++; if (key_code !== 4'h0) begin n_bad++; $display("FAIL middeb_code got=%h exp=0", key_code); end
    rst = 1'b0;
    press_en = 1'b0;
    base = pulse_cnt;
    step(24);
    n_cmp++; if (pulse_cnt - base !== 0) begin n_bad++; $display("FAIL middeb_pulses got=%0d exp=0", pulse_cnt - base); end
    $display("reset mid-debounce: row=%b pulses=%0d", row, pulse_cnt - base);
  endtask

  // Starts at cyc 24 with row2 driven; key row3/col3 held until cyc 96.
  task automatic test_hold_repeat();
    int base;
    int exp_n;
    int exp_cyc[8];
`ifdef KEYPAD_REPEAT_EN
    exp_n = 6;
    exp_cyc = '{40, 60, 68, 76, 84, 92, 0, 0};
`else
    exp_n = 1;
    exp_cyc = '{40, 0, 0, 0, 0, 0, 0, 0};
`endif
    base = pulse_cnt;
    p_row = 2'd3; p_mask = 4'b0111; press_en = 1'b1;
    step(72);
    press_en = 1'b0;
    step(11);
    n_cmp++; if (key_down !== 1'b1) begin n_bad++; $display("FAIL hold_down got=%b exp=1", key_down); end
    step(1);
    n_cmp++; if (key_down !== 1'b0) begin n_bad++; $display("FAIL hold_release got=%b exp=0", key_down); end
    n_cmp++; if (pulse_cnt - base !== exp_n) begin n_bad++; $display("FAIL hold_pulses got=%0d exp=%0d", pulse_cnt - base, exp_n); end
    for (int i = 0; i < exp_n; i++) begin
      n_cmp++; if (pulse_cyc[base + i] !== exp_cyc[i]) begin n_bad++; $display("FAIL hold_pulse%0d_cyc got=%0d exp=%0d", i, pulse_cyc[base + i], exp_cyc[i]); end
      n_cmp++; if (pulse_code[base + i] !== 4'hF) begin n_bad++; $display("FAIL hold_pulse%0d_code got=%h exp=f", i, pulse_code[base + i]); end
    end
    $display("hold: pulses=%0d expected=%0d", pulse_cnt - base, exp_n);
  endtask

  initial begin
    test_reset();
    test_idle_scan();
    test_single_press();
    test_bounce();
    test_multi_key();
    test_reset_mid_debounce();
    test_hold_repeat();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
